uart_echo_test: RTL and testbench

- Board-level UART exerciser running on the 50 MHz board clock.
- 8N1 receiver on RS232_DCE_RXD; every received byte is echoed back on RS232_DCE_TXD and latched on LED.
- Three push-buttons inject fixed ASCII characters into the transmit path.
- Top-level hardware bring-up block for the RS-232 DCE port.

---
 rtl/uart_echo_pkg.sv | 48 ++++
 rtl/uart_echo_rx.sv | 109 ++++++++++
 rtl/uart_echo_test.sv | 176 +++++++++++++++++
 tb/tb_uart_echo_test.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo exerciser.
// Optional 8E1 framing: define UART_PARITY_EN.
package uart_echo_pkg;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;
`endif

  localparam logic [7:0] CHR_W = 8'h57;
  localparam logic [7:0] CHR_E = 8'h45;
  localparam logic [7:0] CHR_N = 8'h4E;

  function automatic int cnt_width(input int clks);
    return $clog2(clks + 1);
  endfunction

  localparam int CLKS_DEF  = 434;
  localparam int CNT_W_DEF = cnt_width(CLKS_DEF);

endpackage

// File: rtl/uart_echo_rx.sv
// UART receiver FSM fed by an already synchronised RXD.
// Optional even-parity check: define UART_PARITY_EN.
module uart_echo_rx
  import uart_echo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic          tick;
  logic          par_pass;

  assign tick = (cnt == CW'(1));

`ifdef UART_PARITY_EN
  logic par_ok;
  assign par_pass = par_ok;
`else
  assign par_pass = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      data      <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_ok    <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (state != RX_IDLE && !tick)
        cnt <= cnt - 1'b1;
      unique case (state)
        RX_IDLE: begin
          if (!rxd) begin
            state <= RX_START;
            cnt   <= HALF;
          end
        end
        RX_START: begin
          if (tick) begin
            if (!rxd) begin
              state <= RX_DATA;
              cnt   <= FULL;
              bitn  <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            sh   <= {rxd, sh[7:1]};
            cnt  <= FULL;
            bitn <= bitn + 3'd1;
            if (bitn == 3'd7)
`ifdef UART_PARITY_EN
              state <= RX_PAR;
`else
              state <= RX_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        RX_PAR: begin
          if (tick) begin
            par_ok <= (rxd == ^sh);
            cnt    <= FULL;
            state  <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (tick) begin
            state <= RX_IDLE;
            if (rxd && par_pass) begin
              data     <= sh;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_test.sv
// RS-232 DCE bring-up: echo received bytes, buttons inject W/E/N.
// Optional 8E1 framing: define UART_PARITY_EN.
module uart_echo_test
  import uart_echo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLK_50MHZ,
  input  logic       RST_N,
  input  logic       BTN_WEST,
  input  logic       BTN_EAST,
  input  logic       BTN_NORTH,
  input  logic       RS232_DCE_RXD,
  output logic       RS232_DCE_TXD,
  output logic [7:0] LED
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

  logic [SYNC_STAGES-1:0] rxd_sync;
  logic [2:0]             btn_sync [SYNC_STAGES];
  logic [2:0]             btn_prev;
  logic [2:0]             btn_rise;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  logic       src_vld;
  logic [7:0] src_byte;
  logic [7:0] hold_data;
  logic       hold_full;
  logic       take;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bitn;
  logic [7:0]    tx_sh;
  logic          tx_tick;
  logic          txd_q;

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      rxd_sync <= '1;
    end else begin
      rxd_sync[0] <= RS232_DCE_RXD;
      for (int i = 1; i < SYNC_STAGES; i++)
        rxd_sync[i] <= rxd_sync[i-1];
    end
  end

  // Unreset so a button held through reset is already the prev level.
  always_ff @(posedge CLK_50MHZ) begin
    btn_sync[0] <= {BTN_NORTH, BTN_EAST, BTN_WEST};
    for (int i = 1; i < SYNC_STAGES; i++)
      btn_sync[i] <= btn_sync[i-1];
    btn_prev <= btn_sync[SYNC_STAGES-1];
  end

  assign btn_rise = btn_sync[SYNC_STAGES-1] & ~btn_prev;

  uart_echo_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (CLK_50MHZ),
    .rst_n    (RST_N),
    .rxd      (rxd_sync[SYNC_STAGES-1]),
    .data     (rx_data),
    .rx_valid (rx_valid),
    .frame_err(rx_err)
  );

  always_comb begin
    src_vld  = 1'b1;
    src_byte = rx_data;
    priority case (1'b1)
      (rx_valid && !rx_err): src_byte = rx_data;
      btn_rise[2]:           src_byte = CHR_N;
      btn_rise[1]:           src_byte = CHR_E;
      btn_rise[0]:           src_byte = CHR_W;
      default:               src_vld  = 1'b0;
    endcase
  end

  assign tx_tick = (tx_cnt == CW'(1));
  // Reload straight from STOP so back-to-back frames have no gap.
  assign take = hold_full &&
    (tx_state == TX_IDLE ||
     (tx_state == TX_STOP && tx_tick));

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (take) begin
      hold_full <= 1'b0;
    end else if (src_vld && !hold_full) begin
      hold_data <= src_byte;
      hold_full <= 1'b1;
    end
  end

`ifdef UART_PARITY_EN
  logic tx_par;
`endif

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bitn  <= '0;
      tx_sh    <= '0;
      txd_q    <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      if (tx_state != TX_IDLE && !tx_tick)
        tx_cnt <= tx_cnt - 1'b1;
      unique case (tx_state)
        TX_IDLE: txd_q <= 1'b1;
        TX_START: begin
          txd_q <= 1'b0;
          if (tx_tick) begin
            tx_state <= TX_DATA;
            tx_cnt   <= FULL;
          end
        end
        TX_DATA: begin
          txd_q <= tx_sh[0];
          if (tx_tick) begin
            tx_sh   <= tx_sh >> 1;
            tx_bitn <= tx_bitn + 3'd1;
            tx_cnt  <= FULL;
            if (tx_bitn == 3'd7)
`ifdef UART_PARITY_EN
              tx_state <= TX_PAR;
`else
              tx_state <= TX_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        TX_PAR: begin
          txd_q <= tx_par;
          if (tx_tick) begin
            tx_state <= TX_STOP;
            tx_cnt   <= FULL;
          end
        end
`endif
        TX_STOP: begin
          txd_q <= 1'b1;
          if (tx_tick)
            tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
      if (take) begin
        tx_state <= TX_START;
        tx_cnt   <= FULL;
        tx_sh    <= hold_data;
        tx_bitn  <= '0;
`ifdef UART_PARITY_EN
        tx_par   <= ^hold_data;
`endif
      end
    end
  end

  assign RS232_DCE_TXD = txd_q;
  assign LED           = rx_data;

endmodule

// File: tb/tb_uart_echo_test.sv
// Scoreboard bench for uart_echo_test at 16 clocks per bit.
// Follows UART_PARITY_EN for frame shape.
module tb_uart_echo_test;
  import uart_echo_pkg::*;

  localparam int C = 16;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bw = 1'b0;
  logic be = 1'b0;
  logic bn = 1'b0;
  logic rxd = 1'b1;
  logic txd;
  logic [7:0] led;

  int total = 0;
  int bad = 0;
  longint cyc = 0;

  typedef struct {
    logic [7:0] b;
    bit         b2b;
  } exp_t;

  exp_t sb[$];
  bit mon_busy = 1'b0;

  uart_echo_test #(
    .CLKS_PER_BIT(C),
    .SYNC_STAGES (2)
  ) dut (
    .CLK_50MHZ    (clk),
    .RST_N        (rst_n),
    .BTN_WEST     (bw),
    .BTN_EAST     (be),
    .BTN_NORTH    (bn),
    .RS232_DCE_RXD(rxd),
    .RS232_DCE_TXD(txd),
    .LED          (led)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NB-1:0] wave(input logic [7:0] b);
`ifdef UART_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Monitor: every TXD start edge opens a frame checked cycle by cycle.
  initial begin : mon
    logic prev;
    logic [NB-1:0] want;
    int errs;
    bit aborted;
    bit unexp;
    exp_t e;
    longint t0;
    longint last_t0;
    prev = 1'b1;
    last_t0 = -1000;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !txd) begin
        mon_busy = 1'b1;
        t0 = cyc;
        errs = 0;
        aborted = 1'b0;
        unexp = (sb.size() == 0);
        if (!unexp) e = sb.pop_front();
        else e = '{8'h00, 1'b0};
        want = wave(e.b);
        for (int n = 0; n < FL; n++) begin
          if (n > 0) @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          if (txd !== want[n / C]) errs++;
        end
        if (!aborted) begin
          if (unexp) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got frame at %0d want none",
                     t0);
          end else begin
            check($sformatf("frame_%02h_bad_cycles", e.b), errs, 0);
            if (e.b2b)
              check($sformatf("frame_%02h_gap", e.b),
                    32'(t0 - last_t0), FL);
          end
        end
        last_t0 = t0;
        mon_busy = 1'b0;
      end
      prev = txd;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_byte(input logic [7:0] b, input bit b2b);
    sb.push_back('{b, b2b});
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    cycles(C);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 4000) begin
      cycles(1);
      n++;
    end
    total++;
    if (n >= 4000) begin
      bad++;
      $display("FAIL %s_timeout: got %0d pending want 0",
               nm, sb.size());
    end
    cycles(FL + 40);
  endtask

  initial begin : watchdog
    #(20 * 90000);
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int txlo;
    int ledbad;
    cycles(1);

    // Reset with WEST held through it: no frame may appear.
    bw = 1'b1;
    cycles(5);
    check("txd_in_reset", txd, 1);
    check("led_in_reset", led, 0);
    rst_n = 1'b1;
    txlo = 0;
    ledbad = 0;
    for (int i = 0; i < 1000; i++) begin
      cycles(1);
      if (txd !== 1'b1) txlo++;
      if (led !== 8'h00) ledbad++;
    end
    check("reset_idle_txd_low_cycles", txlo, 0);
    check("reset_idle_led_bad_cycles", ledbad, 0);
    bw = 1'b0;
    cycles(20);

    expect_byte(8'hA5, 1'b0);
    send_byte(8'hA5, 1'b1);
    check("led_a5", led, 8'hA5);
    drain("echo_a5");

    expect_byte(CHR_E, 1'b0);
    be = 1'b1;
    cycles(3);
    be = 1'b0;
    drain("east_pulse");

    expect_byte(CHR_E, 1'b0);
    be = 1'b1;
    cycles(500);
    be = 1'b0;
    drain("east_hold");

    expect_byte(CHR_N, 1'b0);
    bn = 1'b1;
    bw = 1'b1;
    cycles(50);
    bn = 1'b0;
    bw = 1'b0;
    drain("north_west");

    txlo = 0;
    for (int i = 0; i < 400; i++) begin
      rxd = ~rxd;
      for (int k = 0; k < 5; k++) begin
        cycles(1);
        if (txd !== 1'b1) txlo++;
      end
    end
    rxd = 1'b1;
    cycles(50);
    check("glitch_led", led, 8'hA5);
    check("glitch_txd_low_cycles", txlo, 0);

    send_byte(8'h5A, 1'b0);
    cycles(50);
    check("bad_stop_led", led, 8'hA5);
    cycles(FL);

    expect_byte(8'h31, 1'b0);
    expect_byte(8'h32, 1'b1);
    send_byte(8'h31, 1'b1);
    check("led_31", led, 8'h31);
    send_byte(8'h32, 1'b1);
    check("led_32", led, 8'h32);
    drain("b2b_echo");

    // WEST lands while EAST waits in the holding register.
    expect_byte(CHR_N, 1'b0);
    expect_byte(CHR_E, 1'b1);
    bn = 1'b1;
    cycles(5);
    bn = 1'b0;
    cycles(40);
    be = 1'b1;
    cycles(5);
    be = 1'b0;
    cycles(20);
    bw = 1'b1;
    cycles(5);
    bw = 1'b0;
    drain("hold_drop");

    expect_byte(CHR_E, 1'b0);
    be = 1'b1;
    cycles(5);
    be = 1'b0;
    cycles(40);
    check("mid_frame_txd_low", txd, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_txd", txd, 1);
    cycles(5);
    check("reset_led", led, 0);
    rst_n = 1'b1;
    cycles(FL + 40);
    check("after_abort_txd", txd, 1);

    while (mon_busy) cycles(1);
    check("queue_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
